// File: rtl/reg_file_bank_if.sv
// reg_file_bank_if: read/write/clear bus of the parametrised register file bank
interface reg_file_bank_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
);
  logic                clr_req;
  logic                busy;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [AW-1:0]       rd;
  logic [XLEN-1:0]     rd_data;
  logic                reg_write;
  modport master (output clr_req, rs_addr, rd, rd_data, reg_write, input busy, rs_data);
  modport slave  (input clr_req, rs_addr, rd, rd_data, reg_write, output busy, rs_data);
endinterface

// File: rtl/reg_file_bank.sv
// reg_file_bank: multi-port register file with sequenced hardware/software clear; REG_FILE_WR_BYPASS_EN enables same-cycle write forwarding
module reg_file_bank #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
) (
  input logic           clk,
  input logic           rst_n,
  reg_file_bank_if.slave bus
);
  localparam int NREGS = 2**AW;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t              state;
  logic [AW-1:0]       clr_ptr;
  logic [XLEN-1:0]     regs [NREGS];
  logic [NRD*XLEN-1:0] rs_data;
  assign bus.busy    = state == CLEAR;
  assign bus.rs_data = rs_data;
  // clear sequencer: sweep every index once after reset or a clear request
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == '1) state <= IDLE;
    end else if (bus.clr_req) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end
  // array update: sweep writes zero, otherwise commit writes except to x0
  always_ff @(posedge clk)
    if (state == CLEAR) regs[clr_ptr] <= '0;
    else if (bus.reg_write && bus.rd != '0) regs[bus.rd] <= bus.rd_data;
  // combinational read ports, forced to zero while clearing and for x0
  always_comb begin
    rs_data = '0;
    for (int i = 0; i < NRD; i++)
`ifdef REG_FILE_WR_BYPASS_EN
      rs_data[i*XLEN +: XLEN] = (bus.busy || bus.rs_addr[i*AW +: AW] == '0) ? '0 :
                                (bus.reg_write && bus.rd == bus.rs_addr[i*AW +: AW]) ? bus.rd_data :
                                regs[bus.rs_addr[i*AW +: AW]];
`else
      rs_data[i*XLEN +: XLEN] = (bus.busy || bus.rs_addr[i*AW +: AW] == '0) ? '0 :
                                regs[bus.rs_addr[i*AW +: AW]];
`endif
  end
endmodule

// File: tb/tb_reg_file_bank.sv
// tb_reg_file_bank: randomized self-checking bench against an array-based reference model
module tb_reg_file_bank;
  localparam int N = 32;
  logic clk = 0, rst_n = 0, rst2_n = 0;
  int checks = 0, errors = 0;
  int bcnt = N;
  logic [31:0] m [N];
  logic [63:0] v [3];
  always #5 clk = ~clk;

  reg_file_bank_if #(.XLEN(32), .AW(5), .NRD(2)) bus ();
  reg_file_bank #(.XLEN(32), .AW(5), .NRD(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  reg_file_bank_if #(.XLEN(64), .AW(4), .NRD(3)) bus2 ();
  reg_file_bank #(.XLEN(64), .AW(4), .NRD(3)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (bcnt > 0 || a == 0) return 0;
`ifdef REG_FILE_WR_BYPASS_EN
    if (bus.reg_write && bus.rd == a) return bus.rd_data;
`endif
    return m[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      bcnt = N;
      for (int k = 0; k < N; k++) m[k] = 0;
    end else if (bcnt > 0) bcnt--;
    else begin
      if (bus.reg_write && bus.rd != 0) m[bus.rd] = bus.rd_data;
      if (bus.clr_req) begin
        for (int k = 0; k < N; k++) m[k] = 0;
        bcnt = N;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) begin
      #1;
      checks++;
      if (bus.busy !== 1'b1 || bus.rs_data !== 64'h0) begin
        errors++;
        $display("FAIL reset_hold busy=%b rs_data=%h required busy=1 rs_data=0", bus.busy, bus.rs_data);
      end
      tick();
    end
    rst_n = 1;
    begin
      int n = 0;
      for (int c = 0; c < 40 && bus.busy; c++) begin n++; tick(); end
      checks++;
      if (n !== N || bcnt !== 0) begin
        errors++;
        $display("FAIL reset_busy_len got=%0d required=%0d", n, N);
      end
    end
    for (int a = 0; a < N; a++) begin
      bus.rs_addr = {5'(a), 5'(N - 1 - a)};
      #1;
      checks++;
      if (bus.rs_data !== 64'h0) begin
        errors++;
        $display("FAIL reset_read addr=%0d got=%h required=0", a, bus.rs_data);
      end
    end
  endtask

  task automatic test_write_read();
    bus.reg_write = 1; bus.rd = 5; bus.rd_data = 32'hDEADBEEF;
    tick();
    bus.reg_write = 1; bus.rd = 0; bus.rd_data = 32'h12345678; bus.rs_addr = {5'd5, 5'd5};
    #1;
    checks++;
    if (bus.rs_data !== {2{32'hDEADBEEF}}) begin
      errors++;
      $display("FAIL write_x5 got=%h required=%h", bus.rs_data, {2{32'hDEADBEEF}});
    end
    tick();
    bus.reg_write = 0; bus.rs_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (bus.rs_data !== 64'h0) begin
      errors++;
      $display("FAIL write_x0 got=%h required=0", bus.rs_data);
    end
  endtask

  task automatic test_soft_clear();
    for (int a = 1; a < N; a++) begin
      bus.reg_write = 1; bus.rd = 5'(a); bus.rd_data = 32'(a) * 32'h01010101;
      tick();
    end
    bus.reg_write = 0; bus.rs_addr = {5'd31, 5'd17};
    #1;
    checks++;
    if (bus.rs_data !== {exp_rd(31), exp_rd(17)} || bus.rs_data[31:0] !== 32'h11111111) begin
      errors++;
      $display("FAIL fill_read got=%h required=%h", bus.rs_data, {exp_rd(31), exp_rd(17)});
    end
    bus.clr_req = 1;
    tick();
    bus.clr_req = 0;
    begin
      int n = 0;
      for (int c = 0; c < 40 && bus.busy; c++) begin
        bus.reg_write = (n == 10); bus.rd = 7; bus.rd_data = 32'hAAAA5555;
        n++;
        tick();
      end
      bus.reg_write = 0;
      checks++;
      if (n !== N) begin
        errors++;
        $display("FAIL soft_busy_len got=%0d required=%0d", n, N);
      end
    end
    for (int a = 0; a < N; a += 2) begin
      bus.rs_addr = {5'(a + 1), 5'(a)};
      #1;
      checks++;
      if (bus.rs_data !== {exp_rd(5'(a + 1)), exp_rd(5'(a))}) begin
        errors++;
        $display("FAIL soft_clear_read addr=%0d got=%h required=%h", a, bus.rs_data, {exp_rd(5'(a + 1)), exp_rd(5'(a))});
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    bus.reg_write = 1; bus.rd = 3; bus.rd_data = 32'h3333;
    tick();
    bus.reg_write = 0; bus.clr_req = 1;
    tick();
    bus.clr_req = 0;
    repeat (10) tick();
    rst_n = 0;
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midsweep_rst_busy got=%b required=1", bus.busy);
    end
    tick();
    rst_n = 1;
    begin
      int n = 0;
      for (int c = 0; c < 40 && bus.busy; c++) begin n++; tick(); end
      checks++;
      if (n !== N) begin
        errors++;
        $display("FAIL midsweep_busy_len got=%0d required=%0d", n, N);
      end
    end
    bus.rs_addr = {5'd3, 5'd31};
    #1;
    checks++;
    if (bus.rs_data !== 64'h0) begin
      errors++;
      $display("FAIL midsweep_read got=%h required=0", bus.rs_data);
    end
  endtask

  task automatic test_bypass();
    bus.reg_write = 1; bus.rd = 9; bus.rd_data = 32'h11111111;
    tick();
    bus.rd_data = 32'h00C0FFEE; bus.rs_addr = {5'd0, 5'd9};
    #1;
    checks++;
`ifdef REG_FILE_WR_BYPASS_EN
    if (bus.rs_data[31:0] !== 32'h00C0FFEE) begin
      errors++;
      $display("FAIL bypass_same got=%h required=00c0ffee", bus.rs_data[31:0]);
    end
`else
    if (bus.rs_data[31:0] !== 32'h11111111) begin
      errors++;
      $display("FAIL bypass_same got=%h required=11111111", bus.rs_data[31:0]);
    end
`endif
    tick();
    bus.reg_write = 0;
    #1;
    checks++;
    if (bus.rs_data[31:0] !== 32'h00C0FFEE) begin
      errors++;
      $display("FAIL bypass_next got=%h required=00c0ffee", bus.rs_data[31:0]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      bus.rs_addr   = 10'($urandom);
      bus.rd        = 5'($urandom);
      bus.rd_data   = $urandom;
      bus.reg_write = 1'($urandom);
      bus.clr_req   = ($urandom_range(0, 59) == 0);
      #1;
      checks++;
      if (bus.busy !== (bcnt > 0) || bus.rs_data !== {exp_rd(bus.rs_addr[9:5]), exp_rd(bus.rs_addr[4:0])}) begin
        errors++;
        $display("FAIL random it=%0d busy=%b rs_data=%h required busy=%b rs_data=%h", it, bus.busy, bus.rs_data,
                 bcnt > 0, {exp_rd(bus.rs_addr[9:5]), exp_rd(bus.rs_addr[4:0])});
      end
      tick();
    end
    bus.reg_write = 0; bus.clr_req = 0;
  endtask

  task automatic test_param();
    rst2_n = 1;
    begin
      int n = 0;
      for (int c = 0; c < 30 && bus2.busy; c++) begin n++; tick(); end
      checks++;
      if (n !== 16) begin
        errors++;
        $display("FAIL param_busy_len got=%0d required=16", n);
      end
    end
    for (int k = 0; k < 3; k++) begin
      v[k] = {$urandom, $urandom};
      bus2.reg_write = 1; bus2.rd = 4'(3 + 4 * k); bus2.rd_data = v[k];
      tick();
    end
    bus2.reg_write = 0; bus2.rs_addr = {4'd11, 4'd3, 4'd7};
    #1;
    checks++;
    if (bus2.rs_data !== {v[2], v[0], v[1]}) begin
      errors++;
      $display("FAIL param_read got=%h required=%h", bus2.rs_data, {v[2], v[0], v[1]});
    end
  endtask

  initial begin
    bus.clr_req = 0; bus.reg_write = 0; bus.rd = 0; bus.rd_data = 0; bus.rs_addr = 0;
    bus2.clr_req = 0; bus2.reg_write = 0; bus2.rd = 0; bus2.rd_data = 0; bus2.rs_addr = 0;
    for (int k = 0; k < N; k++) m[k] = 0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_soft_clear();
    test_reset_mid_sweep();
    test_bypass();
    test_random();
    test_param();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
